// File: rtl/nmr_voter_if.sv
// Channel-side and result-side signals of the N-modular-redundancy voter.
interface nmr_voter_if #(
  parameter int WIDTH = 8,
  parameter int N     = 5
);
  logic               in_valid;
  logic [N*WIDTH-1:0] ch_data;
  logic               clear_faults;
  logic               out_valid;
  logic [WIDTH-1:0]   z;
  logic               no_majority;
  logic [N-1:0]       disagree;
  logic [N-1:0]       ch_fault;

  modport master (
    output in_valid, ch_data, clear_faults,
    input  out_valid, z, no_majority, disagree, ch_fault
  );

  modport slave (
    input  in_valid, ch_data, clear_faults,
    output out_valid, z, no_majority, disagree, ch_fault
  );
endinterface

// File: rtl/nmr_voter.sv
// N-way bitwise majority voter with per-channel fault tracking and exclusion.
// Optional re-admission of faulted channels is enabled by defining VOTER_READMIT_EN.
module nmr_voter #(
  parameter int WIDTH       = 8,
  parameter int N           = 5,
  parameter int FAULT_LIMIT = 4,
  parameter int MIN_ACTIVE  = 3,
  parameter int READMIT     = 8
) (
  input  logic        clk,
  input  logic        rst,
  nmr_voter_if.slave  bus
);

  localparam int KW = $clog2(N + 1);
  localparam int CW = $clog2(FAULT_LIMIT + 1);

  if (N < 3 || N > 15) begin : g_bad_n
    $error("nmr_voter: N out of range");
  end
  if (FAULT_LIMIT < 1 || FAULT_LIMIT > 15) begin : g_bad_limit
    $error("nmr_voter: FAULT_LIMIT out of range");
  end
  if (MIN_ACTIVE < 3 || MIN_ACTIVE > N) begin : g_bad_min
    $error("nmr_voter: MIN_ACTIVE out of range");
  end
  if (READMIT < 1) begin : g_bad_readmit
    $error("nmr_voter: READMIT out of range");
  end

  logic                    out_valid_q;
  logic [WIDTH-1:0]        z_q;
  logic                    no_majority_q;
  logic [N-1:0]            disagree_q;
  logic [N-1:0]            fault_q, fault_d;
  logic [N-1:0][CW-1:0]    mis_q, mis_d;

  logic [KW-1:0]           k_act;
  logic [KW-1:0]           ones;
  logic [WIDTH-1:0]        z_vote;
  logic                    tie_any;
  logic [N-1:0]            dis_vec;
  int                      room;

`ifdef VOTER_READMIT_EN
  localparam int RW = $clog2(READMIT + 1);
  logic [N-1:0][RW-1:0]    match_q, match_d;
`endif

  always_comb begin
    k_act   = '0;
    ones    = '0;
    z_vote  = '0;
    tie_any = 1'b0;
    dis_vec = '0;
    for (int i = 0; i < N; i++) k_act = k_act + KW'(!fault_q[i]);
    for (int b = 0; b < WIDTH; b++) begin
      ones = '0;
      for (int i = 0; i < N; i++) ones = ones + KW'(!fault_q[i] && bus.ch_data[i*WIDTH+b]);
      if ({ones, 1'b0} > {1'b0, k_act}) z_vote[b] = 1'b1;
      else if ({ones, 1'b0} == {1'b0, k_act}) tie_any = 1'b1;
    end
    for (int i = 0; i < N; i++) dis_vec[i] = (bus.ch_data[i*WIDTH +: WIDTH] != z_vote);
  end

  // A channel becomes a candidate on the valid mismatch that brings its counter to the
  // limit; grants go lowest index first while the active count stays at or above MIN_ACTIVE.
  always_comb begin
    mis_d   = mis_q;
    fault_d = fault_q;
    room    = int'(k_act) - MIN_ACTIVE;
`ifdef VOTER_READMIT_EN
    match_d = match_q;
`endif
    if (bus.in_valid) begin
      for (int i = 0; i < N; i++) begin
        if (!fault_q[i]) begin
          if (dis_vec[i]) begin
            if (mis_q[i] != CW'(FAULT_LIMIT)) mis_d[i] = mis_q[i] + 1'b1;
            if (mis_q[i] >= CW'(FAULT_LIMIT - 1) && room > 0) begin
              fault_d[i] = 1'b1;
              room       = room - 1;
            end
          end else begin
            mis_d[i] = '0;
          end
        end
`ifdef VOTER_READMIT_EN
        else begin
          if (dis_vec[i]) begin
            match_d[i] = '0;
          end else if (match_q[i] >= RW'(READMIT - 1)) begin
            match_d[i] = '0;
            fault_d[i] = 1'b0;
            mis_d[i]   = '0;
          end else begin
            match_d[i] = match_q[i] + 1'b1;
          end
        end
`endif
      end
    end
    if (bus.clear_faults) begin
      fault_d = '0;
      mis_d   = '0;
`ifdef VOTER_READMIT_EN
      match_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      z_q           <= '0;
      no_majority_q <= 1'b0;
      disagree_q    <= '0;
      fault_q       <= '0;
      mis_q         <= '0;
    end else begin
      out_valid_q <= bus.in_valid;
      fault_q     <= fault_d;
      mis_q       <= mis_d;
      if (bus.in_valid) begin
        z_q           <= z_vote;
        no_majority_q <= tie_any;
        disagree_q    <= dis_vec;
      end
    end
  end

`ifdef VOTER_READMIT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) match_q <= '0;
    else     match_q <= match_d;
  end
`endif

  assign bus.out_valid   = out_valid_q;
  assign bus.z           = z_q;
  assign bus.no_majority = no_majority_q;
  assign bus.disagree    = disagree_q;
  assign bus.ch_fault    = fault_q;

endmodule
